// File: rtl/op_mem_if.sv
// op_mem_if: LSU-side load/store bus of the output-peripheral register file.
// The LSU (master) drives address, lane-aligned store data, store strobe and
// byte-lane enables; the peripheral (slave) returns combinational load data.
interface op_mem_if;
    logic [15:0] i_op_addr;
    logic [31:0] i_st_data;
    logic        i_st_en;
    logic [3:0]  i_bmask;
    logic [31:0] o_ld_data;

    modport master (
        output i_op_addr,
        output i_st_data,
        output i_st_en,
        output i_bmask,
        input  o_ld_data
    );

    modport slave (
        input  i_op_addr,
        input  i_st_data,
        input  i_st_en,
        input  i_bmask,
        output o_ld_data
    );
endinterface

// File: rtl/op_mem.sv
// op_mem: output-peripheral register file of the single-cycle RISC-V core.
// Memory-mapped LEDR / LEDG / HEXLO / HEXHI / LCD registers written by byte-
// masked stores and read back combinationally. Register state drives the
// board pins directly, so a store reaches its pin at the sampling edge.
//
// Optional build macro OP_MEM_HEX_DECODE_EN: each hex digit stores a 4-bit
// nibble and the pin carries its active-low 7-segment decode. Without it the
// raw 7-bit segment pattern is stored and driven unchanged.
module op_mem #(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int          LEDR_W    = 17,
    parameter int          LEDG_W    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    op_mem_if.slave     bus,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
);

`ifdef OP_MEM_HEX_DECODE_EN
    localparam int HEX_W = 4;
`else
    localparam int HEX_W = 7;
`endif

    // Word indices of the mapped registers (address bits [15:2]).
    localparam logic [13:0] WORD_BASE = BASE_ADDR[15:2];
    localparam logic [13:0] LEDR_IDX  = WORD_BASE;
    localparam logic [13:0] LEDG_IDX  = WORD_BASE + 14'd4;
    localparam logic [13:0] HEXLO_IDX = WORD_BASE + 14'd8;
    localparam logic [13:0] HEXHI_IDX = WORD_BASE + 14'd9;
    localparam logic [13:0] LCD_IDX   = WORD_BASE + 14'd12;

    // Byte-lane merge: lanes with we[n]=1 take new data, the rest hold.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  we
    );
        logic [31:0] res;
        res = old_word;
        for (int n = 0; n < 4; n++) begin
            if (we[n]) begin
                res[8*n +: 8] = new_word[8*n +: 8];
            end
        end
        return res;
    endfunction

`ifdef OP_MEM_HEX_DECODE_EN
    // Active-low segment pattern {g,f,e,d,c,b,a} for a hexadecimal nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [13:0] word_idx;
    logic [3:0]  lane_we;
    logic        sel_ledr;
    logic        sel_ledg;
    logic        sel_hexlo;
    logic        sel_hexhi;
    logic        sel_lcd;
    logic        unused_addr_bits;

    assign word_idx = bus.i_op_addr[15:2];
    // Byte offset within the word is irrelevant: lanes come from i_bmask.
    assign unused_addr_bits = ^bus.i_op_addr[1:0];

    // Register select decode and store-gated lane enables.
    always_comb begin
        sel_ledr  = (word_idx == LEDR_IDX);
        sel_ledg  = (word_idx == LEDG_IDX);
        sel_hexlo = (word_idx == HEXLO_IDX);
        sel_hexhi = (word_idx == HEXHI_IDX);
        sel_lcd   = (word_idx == LCD_IDX);
        lane_we   = bus.i_st_en ? bus.i_bmask : 4'b0000;
    end

    // ------------------------------------------------------------------
    // LED and LCD registers
    // ------------------------------------------------------------------
    logic [LEDR_W-1:0] ledr_q;
    logic [LEDR_W-1:0] ledr_d;
    logic [LEDG_W-1:0] ledg_q;
    logic [LEDG_W-1:0] ledg_d;
    logic [31:0]       lcd_q;
    logic [31:0]       lcd_d;
    logic [31:0]       ledr_full;
    logic [31:0]       ledg_full;

    // Next-state for the word registers; bits above the implemented
    // width are simply dropped after the lane merge.
    always_comb begin
        ledr_full = merge_lanes(32'(ledr_q), bus.i_st_data,
                                sel_ledr ? lane_we : 4'b0000);
        ledg_full = merge_lanes(32'(ledg_q), bus.i_st_data,
                                sel_ledg ? lane_we : 4'b0000);
        lcd_d     = merge_lanes(lcd_q, bus.i_st_data,
                                sel_lcd ? lane_we : 4'b0000);
        ledr_d    = ledr_full[LEDR_W-1:0];
        ledg_d    = ledg_full[LEDG_W-1:0];
    end

    // Word register flop banks, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
        end else begin
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
            lcd_q  <= lcd_d;
        end
    end

    // ------------------------------------------------------------------
    // Hex digit registers: digit gi lives in byte (gi % 4) of HEXLO (gi<4)
    // or HEXHI (gi>=4).
    // ------------------------------------------------------------------
    logic [63:0] hex_rd;   // read-back image {HEXHI, HEXLO}
    logic [55:0] hex_pin;  // 7 pin bits per digit

    for (genvar gi = 0; gi < 8; gi++) begin : g_hex
        localparam int LANE = gi % 4;
        logic             hex_sel;
        logic [HEX_W-1:0] hex_q;
        logic [HEX_W-1:0] hex_d;

        assign hex_sel = (gi < 4) ? sel_hexlo : sel_hexhi;

        // Digit next-state: only the stored low bits of the lane are kept.
        always_comb begin
            hex_d = hex_q;
            if (hex_sel && lane_we[LANE]) begin
                hex_d = bus.i_st_data[8*LANE +: HEX_W];
            end
        end

        // Digit flop bank, cleared asynchronously.
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                hex_q <= '0;
            end else begin
                hex_q <= hex_d;
            end
        end

        assign hex_rd[8*gi +: 8] = 8'(hex_q);
`ifdef OP_MEM_HEX_DECODE_EN
        assign hex_pin[7*gi +: 7] = seg_decode(hex_q);
`else
        assign hex_pin[7*gi +: 7] = hex_q;
`endif
    end

    // ------------------------------------------------------------------
    // Load data: combinational from current state, so a same-cycle store
    // is visible only from the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.o_ld_data = 32'h0;
        if (sel_ledr) begin
            bus.o_ld_data = 32'(ledr_q);
        end else if (sel_ledg) begin
            bus.o_ld_data = 32'(ledg_q);
        end else if (sel_hexlo) begin
            bus.o_ld_data = hex_rd[31:0];
        end else if (sel_hexhi) begin
            bus.o_ld_data = hex_rd[63:32];
        end else if (sel_lcd) begin
            bus.o_ld_data = lcd_q;
        end
    end

    // ------------------------------------------------------------------
    // Pins
    // ------------------------------------------------------------------
    assign o_io_ledr = 32'(ledr_q);
    assign o_io_ledg = 32'(ledg_q);
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_pin[6:0];
    assign o_io_hex1 = hex_pin[13:7];
    assign o_io_hex2 = hex_pin[20:14];
    assign o_io_hex3 = hex_pin[27:21];
    assign o_io_hex4 = hex_pin[34:28];
    assign o_io_hex5 = hex_pin[41:35];
    assign o_io_hex6 = hex_pin[48:42];
    assign o_io_hex7 = hex_pin[55:49];

endmodule

// File: tb/tb_op_mem.sv
// tb_op_mem: scoreboard bench for op_mem. A driver issues one transaction
// per cycle shortly after the rising edge, pushes the expected load data and
// pin values from a byte-level reference model, and a monitor pops and
// compares them on the falling edge. Honors OP_MEM_HEX_DECODE_EN.
module tb_op_mem;

    logic clk;
    logic rst_n;

    op_mem_if bus ();

    logic [31:0] io_ledr;
    logic [31:0] io_ledg;
    logic [31:0] io_lcd;
    logic [6:0]  io_hex [8];

    op_mem dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .bus       (bus),
        .o_io_ledr (io_ledr),
        .o_io_ledg (io_ledg),
        .o_io_hex0 (io_hex[0]),
        .o_io_hex1 (io_hex[1]),
        .o_io_hex2 (io_hex[2]),
        .o_io_hex3 (io_hex[3]),
        .o_io_hex4 (io_hex[4]),
        .o_io_hex5 (io_hex[5]),
        .o_io_hex6 (io_hex[6]),
        .o_io_hex7 (io_hex[7]),
        .o_io_lcd  (io_lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
`ifdef OP_MEM_HEX_DECODE_EN
    localparam logic [7:0] HEX_KEEP = 8'h0F;
`else
    localparam logic [7:0] HEX_KEEP = 8'h7F;
`endif
    localparam logic [31:0] LEDR_KEEP = (32'd1 << 17) - 32'd1;
    localparam logic [31:0] LEDG_KEEP = 32'h0000_00FF;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [31:0] m_ledr;
    logic [31:0] m_ledg;
    logic [31:0] m_lcd;
    logic [7:0]  m_hex [8];

    function automatic int reg_offset(input logic [15:0] a);
        return int'({a[15:2], 2'b00}) - 'h7000;
    endfunction

    task automatic model_clear();
        m_ledr = 0;
        m_ledg = 0;
        m_lcd  = 0;
        for (int n = 0; n < 8; n++) m_hex[n] = 0;
    endtask

    task automatic model_store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        int off;
        off = reg_offset(a);
        for (int n = 0; n < 4; n++) begin
            if (m[n]) begin
                case (off)
                    'h00: m_ledr[8*n +: 8] = d[8*n +: 8];
                    'h10: m_ledg[8*n +: 8] = d[8*n +: 8];
                    'h20: m_hex[n]         = d[8*n +: 8] & HEX_KEEP;
                    'h24: m_hex[n+4]       = d[8*n +: 8] & HEX_KEEP;
                    'h30: m_lcd[8*n +: 8]  = d[8*n +: 8];
                    default: ;
                endcase
            end
        end
        m_ledr = m_ledr & LEDR_KEEP;
        m_ledg = m_ledg & LEDG_KEEP;
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (reg_offset(a))
            'h00:    return m_ledr;
            'h10:    return m_ledg;
            'h20:    return {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
            'h24:    return {m_hex[7], m_hex[6], m_hex[5], m_hex[4]};
            'h30:    return m_lcd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [6:0] model_pin(input int n);
`ifdef OP_MEM_HEX_DECODE_EN
        logic [3:0] nib;
        nib = m_hex[n][3:0];
        return seg_tab[nib];
`else
        return m_hex[n][6:0];
`endif
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;   // 0 ld, 1 ledr, 2 ledg, 3 lcd, 4..11 hex0..7
        logic [31:0] exp;
        int          txn;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    function automatic logic [31:0] dut_value(input int kind);
        case (kind)
            0:       return bus.o_ld_data;
            1:       return io_ledr;
            2:       return io_ledg;
            3:       return io_lcd;
            default: return 32'(io_hex[kind-4]);
        endcase
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            0:       return "ld_data";
            1:       return "ledr";
            2:       return "ledg";
            3:       return "lcd";
            default: return $sformatf("hex%0d", kind - 4);
        endcase
    endfunction

    task automatic push_exp(input int kind, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.txn  = txn;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every pending expectation away from the active edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = dut_value(e.kind);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s txn %0d: got %08h expected %08h",
                             kind_name(e.kind), e.txn, act, e.exp);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_cycle(input logic rst_v, input logic st, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        @(posedge clk);
        #1;
        rst_n         = rst_v;
        bus.i_st_en   = st;
        bus.i_op_addr = a;
        bus.i_st_data = d;
        bus.i_bmask   = m;
        if (!rst_v) model_clear();
        push_exp(0, model_read(a));
        push_exp(1, m_ledr);
        push_exp(2, m_ledg);
        push_exp(3, m_lcd);
        for (int n = 0; n < 8; n++) push_exp(4 + n, 32'(model_pin(n)));
        $display("txn %0d rst_n=%0b st=%0b addr=%04h data=%08h mask=%h exp_ld=%08h",
                 txn, rst_v, st, a, d, m, model_read(a));
        if (rst_v && st) model_store(a, d, m);
        txn++;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 7))
            0: a = 16'h7000;
            1: a = 16'h7010;
            2: a = 16'h7020;
            3: a = 16'h7024;
            4: a = 16'h7030;
            5: a = 16'h7000 + 16'($urandom_range(0, 63) * 4);
            6: a = 16'($urandom);
            default: a = 16'h7FFC;
        endcase
        if (a[15:12] == 4'h7) a[1:0] = 2'($urandom);
        return a;
    endfunction

    initial begin
        logic [31:0] rd;
        rst_n         = 1'b0;
        bus.i_st_en   = 1'b0;
        bus.i_op_addr = 16'h0;
        bus.i_st_data = 32'h0;
        bus.i_bmask   = 4'h0;
        model_clear();

        // Reset held, then released; loads of cleared registers.
        do_cycle(1'b0, 1'b0, 16'h7000, 32'h0, 4'h0);
        do_cycle(1'b0, 1'b1, 16'h7030, 32'hFFFF_FFFF, 4'hF);
        do_cycle(1'b1, 1'b0, 16'h7000, 32'h0, 4'h0);
        do_cycle(1'b1, 1'b0, 16'h7010, 32'h0, 4'h0);
        do_cycle(1'b1, 1'b0, 16'h7030, 32'h0, 4'h0);
        // LEDR word store: upper bits discarded; same-cycle read shows old value.
        do_cycle(1'b1, 1'b1, 16'h7000, 32'hFFFF_FFFF, 4'hF);
        do_cycle(1'b1, 1'b0, 16'h7000, 32'h0, 4'h0);
        // LCD byte-lane merge.
        do_cycle(1'b1, 1'b1, 16'h7030, 32'hAABB_CCDD, 4'hF);
        do_cycle(1'b1, 1'b1, 16'h7030, 32'h1122_3344, 4'b0100);
        do_cycle(1'b1, 1'b0, 16'h7032, 32'h0, 4'h0);
        // Hex stores, both halves.
        do_cycle(1'b1, 1'b1, 16'h7020, 32'h7F08_4012, 4'hF);
        do_cycle(1'b1, 1'b1, 16'h7024, 32'h8F3C_A5E1, 4'hF);
        do_cycle(1'b1, 1'b0, 16'h7020, 32'h0, 4'h0);
        do_cycle(1'b1, 1'b0, 16'h7024, 32'h0, 4'h0);
        // Unmapped store and zero-mask store.
        do_cycle(1'b1, 1'b1, 16'h7FFC, 32'hDEAD_BEEF, 4'hF);
        do_cycle(1'b1, 1'b1, 16'h7000, 32'h0, 4'h0);
        do_cycle(1'b1, 1'b0, 16'h7FFC, 32'h0, 4'h0);
        // LEDG = 5A, then asynchronous reset between edges with a store pending.
        do_cycle(1'b1, 1'b1, 16'h7010, 32'h1234_565A, 4'hF);
        do_cycle(1'b1, 1'b0, 16'h7010, 32'h0, 4'h0);
        do_cycle(1'b0, 1'b1, 16'h7010, 32'h0000_00FF, 4'hF);
        do_cycle(1'b1, 1'b1, 16'h7010, 32'h0000_0033, 4'h1);
        do_cycle(1'b1, 1'b0, 16'h7010, 32'h0, 4'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            do_cycle(($urandom_range(0, 49) != 0), 1'($urandom), rand_addr(),
                     $urandom, 4'($urandom));
        end

        @(posedge clk);
        #1;
        bus.i_st_en = 1'b0;
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
